// File: rtl/board_refresh_pkg.sv
// Shared definitions for the board-state engine and its piece-shape lookup.
// Contents:
//   BOARD_WIDTH / BOARD_HEIGHT : default board geometry (columns / rows)
//   piece_type_t               : piece codes, T_NONE = 0, T_I..T_L = 1..7
//   state_t                    : refresh FSM encoding
//   SHAPE_TABLE / shape_mask() : 4x4 occupancy masks, bit r*4+c = (col c, row r)
package board_refresh_pkg;

    localparam int BOARD_WIDTH  = 10;
    localparam int BOARD_HEIGHT = 20;

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_I    = 3'd1,
        T_O    = 3'd2,
        T_T    = 3'd3,
        T_S    = 3'd4,
        T_Z    = 3'd5,
        T_J    = 3'd6,
        T_L    = 3'd7
    } piece_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rows of the table are piece types I..L, columns are rotations 0..3.
    localparam logic [15:0] SHAPE_TABLE [7][4] = '{
        '{16'h00F0, 16'h4444, 16'h0F00, 16'h2222},   // I
        '{16'h0660, 16'h0660, 16'h0660, 16'h0660},   // O
        '{16'h0072, 16'h0262, 16'h0270, 16'h0232},   // T
        '{16'h0036, 16'h0231, 16'h0036, 16'h0231},   // S
        '{16'h0063, 16'h0132, 16'h0063, 16'h0132},   // Z
        '{16'h0071, 16'h0226, 16'h0470, 16'h0322},   // J
        '{16'h0074, 16'h0622, 16'h0170, 16'h0223}    // L
    };

    function automatic logic [15:0] shape_mask(input logic [2:0] piece, input logic [1:0] rot);
        logic [15:0] result;
        result = '0;
        if (piece != T_NONE) begin
            result = SHAPE_TABLE[3'(piece - 3'd1)][rot];
        end
        return result;
    endfunction

endpackage

// File: rtl/board_refresh_mask_rom.sv
// piece_mask_rom: combinational (piece type, rotation) -> 16-bit occupancy mask.
// Also used by the collision-check logic that feeds the piece controller.
// Ports:
//   piece_type in  3   piece code, 0 = no piece (empty mask)
//   dir        in  2   rotation 0..3
//   mask       out 16  bit r*4+c set = cell (column c, row r) of the 4x4 box
module piece_mask_rom
    import board_refresh_pkg::*;
(
    input  logic [2:0]  piece_type,
    input  logic [1:0]  dir,
    output logic [15:0] mask
);

    assign mask = shape_mask(piece_type, dir);

endmodule

// File: rtl/board_refresh.sv
// board_refresh: merges a locked piece into the stored board, then removes
// full rows bottom-up while compacting the board, and answers with a one-cycle
// refresh_done pulse.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   refresh            one-cycle lock request (ignored while busy)
//   x, y               piece bounding-box column / row origin
//   piece_type, dir    piece code (0 = none) and rotation
//   rd_row / rd_data   combinational row read port, zero beyond the board
//   refresh_done       one-cycle pulse when lock and clear are complete
//   busy               high whenever the FSM is not idle
//   overflow           row 0 or row 1 of the board is occupied
//   lines_last         rows cleared by the most recent refresh
//   lines_total        cumulative cleared rows, saturating at 0xFFFF
module board_refresh
    import board_refresh_pkg::*;
#(
    parameter int WIDTH  = BOARD_WIDTH,
    parameter int HEIGHT = BOARD_HEIGHT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             refresh,
    input  logic [4:0]       x,
    input  logic [4:0]       y,
    input  logic [2:0]       piece_type,
    input  logic [1:0]       dir,
    input  logic [4:0]       rd_row,
    output logic [WIDTH-1:0] rd_data,
    output logic             refresh_done,
    output logic             busy,
    output logic             overflow,
    output logic [2:0]       lines_last,
    output logic [15:0]      lines_total
);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  board      [HEIGHT];
    logic [WIDTH-1:0]  locked     [HEIGHT];
    logic [WIDTH-1:0]  piece_rows [4];
    logic [4:0]        ptr;
    logic [2:0]        count;
    logic [4:0]        x_q;
    logic [4:0]        y_q;
    logic [2:0]        type_q;
    logic [1:0]        dir_q;
    logic [15:0]       mask;
    logic              row_full;
    logic [16:0]       total_sum;

    piece_mask_rom u_mask_rom (
        .piece_type (type_q),
        .dir        (dir_q),
        .mask       (mask)
    );

    assign row_full     = &board[ptr];
    assign total_sum    = {1'b0, lines_total} + 17'(count);
    assign refresh_done = (state == DONE);
    assign busy         = (state != IDLE);
    assign overflow     = (|board[0]) | (|board[1]);
    assign rd_data      = (rd_row < 5'(HEIGHT)) ? board[rd_row] : '0;

    // Board image with the captured piece ORed in. Shifting the zero-extended
    // mask nibble left by x drops columns >= WIDTH instead of wrapping, and the
    // 6-bit row sum never matches a board row once it runs past the bottom.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            piece_rows[r] = WIDTH'(mask[r*4 +: 4]) << x_q;
        end
        for (int i = 0; i < HEIGHT; i++) begin
            locked[i] = board[i];
            for (int r = 0; r < 4; r++) begin
                if (({1'b0, y_q} + 6'(r)) == 6'(i)) begin
                    locked[i] = locked[i] | piece_rows[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SCAN stays on the same row after a clear so the row shifted down into
    // the pointer position is tested again on the next cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (refresh) next_state = LOCK;
            LOCK:    next_state = SCAN;
            SCAN:    if (!row_full && ptr == 5'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < HEIGHT; i++) begin
                board[i] <= '0;
            end
            ptr         <= 5'(HEIGHT - 1);
            count       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            type_q      <= '0;
            dir_q       <= '0;
            lines_last  <= '0;
            lines_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (refresh) begin
                        x_q    <= x;
                        y_q    <= y;
                        type_q <= piece_type;
                        dir_q  <= dir;
                    end
                end
                LOCK: begin
                    for (int i = 0; i < HEIGHT; i++) begin
                        board[i] <= locked[i];
                    end
                    ptr   <= 5'(HEIGHT - 1);
                    count <= '0;
                end
                SCAN: begin
                    if (row_full) begin
                        for (int k = 0; k < HEIGHT; k++) begin
                            if (k == 0) begin
                                board[k] <= '0;
                            end else if (5'(k) <= ptr) begin
                                board[k] <= board[k-1];
                            end
                        end
                        count <= count + 3'd1;
                    end else if (ptr != 5'd0) begin
                        ptr <= ptr - 5'd1;
                    end
                end
                DONE: begin
                    lines_last  <= count;
                    lines_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_refresh.sv
// Directed self-checking bench for board_refresh: reset state, empty-board
// lock, single and four-line clears, edge clipping, reset during SCAN,
// overflow and a refresh pulse issued while busy.
module tb_board_refresh;

    logic        clk;
    logic        rstn;
    logic        refresh;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [2:0]  piece_type;
    logic [1:0]  dir;
    logic [4:0]  rd_row;
    logic [9:0]  rd_data;
    logic        refresh_done;
    logic        busy;
    logic        overflow;
    logic [2:0]  lines_last;
    logic [15:0] lines_total;

    int checks = 0;
    int errors = 0;

    board_refresh dut (
        .clk          (clk),
        .rstn         (rstn),
        .refresh      (refresh),
        .x            (x),
        .y            (y),
        .piece_type   (piece_type),
        .dir          (dir),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .refresh_done (refresh_done),
        .busy         (busy),
        .overflow     (overflow),
        .lines_last   (lines_last),
        .lines_total  (lines_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic readRow(input int r, output logic [31:0] data);
        rd_row = 5'(r);
        #1;
        data = 32'(rd_data);
    endtask

    // Issues one refresh and waits (bounded) for refresh_done. lat counts the
    // edges from the sampling edge (as 1) up to the edge after which
    // refresh_done is seen high. Optionally pulses a second refresh mid-run.
    task automatic applyStimulus(input int px, input int py, input int pt, input int pd,
                                 input bit inject, output int lat,
                                 output logic ovf_done, output logic busy_lock);
        @(negedge clk);
        x          = 5'(px);
        y          = 5'(py);
        piece_type = 3'(pt);
        dir        = 2'(pd);
        refresh    = 1'b1;
        @(posedge clk);
        #1;
        refresh   = 1'b0;
        lat       = 1;
        busy_lock = busy;
        while (!refresh_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (inject && lat == 5) begin
                x          = 5'd0;
                y          = 5'd10;
                piece_type = 3'd1;
                dir        = 2'd0;
                refresh    = 1'b1;
            end
            if (lat == 6) refresh = 1'b0;
        end
        ovf_done = overflow;
        @(posedge clk);
        #1;
    endtask

    task automatic watchIdle(input int cycles, output int busy_hits, output int done_hits);
        busy_hits = 0;
        done_hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_hits++;
            if (refresh_done) done_hits++;
        end
    endtask

    initial begin
        int          lat;
        logic        ovf;
        logic        bl;
        logic [31:0] data;
        int          bh;
        int          dh;

        rstn       = 1'b0;
        refresh    = 1'b0;
        x          = '0;
        y          = '0;
        piece_type = '0;
        dir        = '0;
        rd_row     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        // Reset state
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(refresh_done), 32'd0);
        checkOutput("rst_lines_last", 32'(lines_last), 32'd0);
        checkOutput("rst_lines_total", 32'(lines_total), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        readRow(19, data);
        checkOutput("rst_row19", data, 32'h000);

        // Empty-board lock: I dir0 at x=3, y=18 lands in row 19 cols 3..6
        applyStimulus(3, 18, 1, 0, 1'b0, lat, ovf, bl);
        checkOutput("empty_latency", 32'(lat), 32'd22);
        checkOutput("empty_busy", 32'(bl), 32'd1);
        readRow(19, data);
        checkOutput("empty_row19", data, 32'h078);
        readRow(18, data);
        checkOutput("empty_row18", data, 32'h000);
        checkOutput("empty_lines_last", 32'(lines_last), 32'd0);
        checkOutput("empty_busy_after", 32'(busy), 32'd0);

        // Single line clear
        doReset();
        applyStimulus(0, 18, 1, 0, 1'b0, lat, ovf, bl);
        checkOutput("single_lat1", 32'(lat), 32'd22);
        applyStimulus(4, 18, 1, 0, 1'b0, lat, ovf, bl);
        applyStimulus(7, 17, 2, 0, 1'b0, lat, ovf, bl);
        checkOutput("single_latency", 32'(lat), 32'd23);
        readRow(19, data);
        checkOutput("single_row19", data, 32'h300);
        readRow(18, data);
        checkOutput("single_row18", data, 32'h000);
        checkOutput("single_lines_last", 32'(lines_last), 32'd1);
        checkOutput("single_lines_total", 32'(lines_total), 32'd1);

        // Reset mid-SCAN aborts without a refresh_done
        @(negedge clk);
        x          = 5'd0;
        y          = 5'd10;
        piece_type = 3'd2;
        dir        = 2'd0;
        refresh    = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midrst_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        readRow(19, data);
        checkOutput("midrst_row19", data, 32'h000);
        readRow(11, data);
        checkOutput("midrst_row11", data, 32'h000);
        checkOutput("midrst_lines_total", 32'(lines_total), 32'd0);
        watchIdle(30, bh, dh);
        checkOutput("midrst_busy_hits", 32'(bh), 32'd0);
        checkOutput("midrst_done_hits", 32'(dh), 32'd0);

        // Four-line clear: cols 0..7 by horizontal I, col 8 by vertical I,
        // then a vertical I in col 9 completes rows 16..19 together
        for (int r = 15; r <= 18; r++) begin
            applyStimulus(0, r, 1, 0, 1'b0, lat, ovf, bl);
            applyStimulus(4, r, 1, 0, 1'b0, lat, ovf, bl);
        end
        applyStimulus(6, 16, 1, 1, 1'b0, lat, ovf, bl);
        readRow(17, data);
        checkOutput("four_row17_before", data, 32'h1FF);
        applyStimulus(7, 16, 1, 1, 1'b0, lat, ovf, bl);
        checkOutput("four_latency", 32'(lat), 32'd26);
        for (int r = 16; r <= 19; r++) begin
            readRow(r, data);
            checkOutput($sformatf("four_row%0d", r), data, 32'h000);
        end
        checkOutput("four_lines_last", 32'(lines_last), 32'd4);
        checkOutput("four_lines_total", 32'(lines_total), 32'd4);

        // Clipping at the right and bottom edges, out-of-range read rows
        doReset();
        applyStimulus(8, 18, 1, 0, 1'b0, lat, ovf, bl);
        checkOutput("clip_latency", 32'(lat), 32'd22);
        readRow(19, data);
        checkOutput("clip_right_row19", data, 32'h300);
        applyStimulus(0, 18, 1, 1, 1'b0, lat, ovf, bl);
        readRow(19, data);
        checkOutput("clip_bottom_row19", data, 32'h304);
        readRow(18, data);
        checkOutput("clip_bottom_row18", data, 32'h004);
        readRow(0, data);
        checkOutput("clip_row0", data, 32'h000);
        readRow(20, data);
        checkOutput("read_row20", data, 32'h000);
        readRow(31, data);
        checkOutput("read_row31", data, 32'h000);

        // Overflow and a refresh pulse while busy
        doReset();
        #1;
        checkOutput("ovf_before", 32'(overflow), 32'd0);
        applyStimulus(3, 0, 2, 0, 1'b1, lat, ovf, bl);
        checkOutput("ovf_latency", 32'(lat), 32'd22);
        checkOutput("ovf_at_done", 32'(ovf), 32'd1);
        readRow(1, data);
        checkOutput("ovf_row1", data, 32'h030);
        readRow(2, data);
        checkOutput("ovf_row2", data, 32'h030);
        readRow(11, data);
        checkOutput("ignored_row11", data, 32'h000);
        watchIdle(30, bh, dh);
        checkOutput("ignored_busy_hits", 32'(bh), 32'd0);
        checkOutput("ignored_done_hits", 32'(dh), 32'd0);
        checkOutput("ovf_level", 32'(overflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
